// File: rtl/dma_channel_regfile.sv
// DMA channel register file with byte-wise CPU programming and a
// per-transfer address/count engine with terminal count and autoinit.
// Ports:
//   CLK, RESET       clock and async active-high reset
//   prog_*           CPU programming bus (byte strobes, sel, channel, data)
//   xfer_step/ch     transfer-completed strobe and serviced channel
//   xfer_addr        current address of xfer_ch (combinational)
//   tc_pulse         one-cycle terminal-count pulse (registered)
//   mode_flat, command, mask, request, byte_ptr   register views
module dma_channel_regfile #(
  parameter int NUM_CH = 4,
  parameter int W = 16,
  localparam int NB = W / 8,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int BW = (NB > 1) ? $clog2(NB) : 1,
  localparam int SN = (NUM_CH < 4) ? NUM_CH : 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              prog_wr,
  input  logic              prog_rd,
  input  logic [2:0]        prog_sel,
  input  logic [CW-1:0]     prog_ch,
  input  logic [7:0]        prog_din,
  output logic [7:0]        prog_dout,
  input  logic              xfer_step,
  input  logic [CW-1:0]     xfer_ch,
  output logic [W-1:0]      xfer_addr,
  output logic              tc_pulse,
  output logic [6*NUM_CH-1:0] mode_flat,
  output logic [7:0]        command,
  output logic [NUM_CH-1:0] mask,
  output logic [NUM_CH-1:0] request,
  output logic [BW-1:0]     byte_ptr
);

  logic [W-1:0]      baseAddr [NUM_CH];
  logic [W-1:0]      curAddr  [NUM_CH];
  logic [W-1:0]      baseCnt  [NUM_CH];
  logic [W-1:0]      curCnt   [NUM_CH];
  logic [5:0]        mode     [NUM_CH];
  logic [NUM_CH-1:0] tc;
  logic [NUM_CH-1:0] tcNext;
  logic [BW-1:0]     bytePtr;
  logic [BW-1:0]     ptrNext;

  logic doWr;
  logic doRd;
  logic isAc;
  logic chOk;
  logic xOk;
  logic stepOk;
  logic terminal;
  logic statRd;
  logic mClr;

  logic [W-1:0] xAddr;
  logic [W-1:0] xCnt;
  logic [5:0]   xMode;
  logic [W-1:0] xBaseA;
  logic [W-1:0] xBaseC;
  logic [W-1:0] stepAddr;
  logic [W-1:0] stepCnt;
  logic [7:0]   acByte;
  logic [7:0]   statusByte;
  logic [7:0]   rdByte;

  // A write always beats a simultaneous read.
  assign doWr   = prog_wr;
  assign doRd   = prog_rd & ~prog_wr;
  assign isAc   = (prog_sel[2:1] == 2'b00);
  assign statRd = doRd & (prog_sel == 3'd6);
  assign mClr   = doRd & (prog_sel == 3'd7);

  // Channel indices may exceed NUM_CH when it is not a power of two.
  assign chOk = ({1'b0, prog_ch} < (CW+1)'(NUM_CH));
  assign xOk  = ({1'b0, xfer_ch} < (CW+1)'(NUM_CH));

  // Programming addr/count of the serviced channel drops the step.
  assign stepOk = xfer_step & xOk
                & ~(doWr & isAc & (prog_ch == xfer_ch));

  assign ptrNext = (bytePtr == BW'(NB-1)) ? '0
                 : bytePtr + BW'(1);

  assign byte_ptr  = bytePtr;
  assign xfer_addr = xAddr;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      mode_flat[6*i +: 6] = mode[i];
    end
  end

  always_comb begin
    xAddr  = '0;
    xCnt   = '0;
    xMode  = '0;
    xBaseA = '0;
    xBaseC = '0;
    if (xOk) begin
      xAddr  = curAddr[xfer_ch];
      xCnt   = curCnt[xfer_ch];
      xMode  = mode[xfer_ch];
      xBaseA = baseAddr[xfer_ch];
      xBaseC = baseCnt[xfer_ch];
    end
    terminal = stepOk & (xCnt == '0);
    stepAddr = xMode[3] ? xAddr - W'(1)
                        : xAddr + W'(1);
    stepCnt  = xCnt - W'(1);
    if (terminal && xMode[2]) begin
      stepAddr = xBaseA;
      stepCnt  = xBaseC;
    end
  end

  // Master clear wins over a same-cycle terminal count;
  // a status read only clears flags already set.
  always_comb begin
    tcNext = tc;
    if (statRd) tcNext = '0;
    if (terminal) tcNext[xfer_ch] = 1'b1;
    if (mClr) tcNext = '0;
  end

  always_comb begin
    acByte     = '0;
    statusByte = '0;
    rdByte     = '0;
    if (chOk) begin
      for (int b = 0; b < NB; b++) begin
        if (bytePtr == BW'(b)) begin
          acByte = prog_sel[0]
                 ? curCnt[prog_ch][8*b +: 8]
                 : curAddr[prog_ch][8*b +: 8];
        end
      end
    end
    for (int i = 0; i < SN; i++) begin
      statusByte[4+i] = request[i];
      statusByte[i]   = tc[i];
    end
    unique case (prog_sel)
      3'd0, 3'd1: rdByte = acByte;
      3'd2: if (chOk) rdByte = {2'b00, mode[prog_ch]};
      3'd3: rdByte = command;
      3'd4: rdByte = 8'(request);
      3'd5: rdByte = 8'(mask);
      3'd6: rdByte = statusByte;
      default: rdByte = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_CH; i++) begin
        baseAddr[i] <= '0;
        curAddr[i]  <= '0;
        baseCnt[i]  <= '0;
        curCnt[i]   <= '0;
        mode[i]     <= '0;
      end
      command   <= '0;
      request   <= '0;
      mask      <= '1;
      tc        <= '0;
      bytePtr   <= '0;
      prog_dout <= '0;
      tc_pulse  <= 1'b0;
    end else begin
      tc       <= tcNext;
      tc_pulse <= terminal;
      if (stepOk) begin
        curAddr[xfer_ch] <= stepAddr;
        curCnt[xfer_ch]  <= stepCnt;
      end
      if (doWr) begin
        unique case (prog_sel)
          3'd0, 3'd1: begin
            if (chOk) begin
              for (int b = 0; b < NB; b++) begin
                if (bytePtr == BW'(b)) begin
                  if (prog_sel[0]) begin
                    baseCnt[prog_ch][8*b +: 8] <= prog_din;
                    curCnt[prog_ch][8*b +: 8]  <= prog_din;
                  end else begin
                    baseAddr[prog_ch][8*b +: 8] <= prog_din;
                    curAddr[prog_ch][8*b +: 8]  <= prog_din;
                  end
                end
              end
            end
            bytePtr <= ptrNext;
          end
          3'd2: if (chOk) mode[prog_ch] <= prog_din[5:0];
          3'd3: command <= prog_din;
          3'd4: if (chOk) request[prog_ch] <= prog_din[0];
          3'd5: if (chOk) mask[prog_ch] <= prog_din[0];
          3'd7: bytePtr <= '0;
          default: ;
        endcase
      end else if (doRd) begin
        prog_dout <= rdByte;
        if (isAc) bytePtr <= ptrNext;
        if (mClr) begin
          command <= '0;
          request <= '0;
          mask    <= '1;
          bytePtr <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_channel_regfile.sv
// Bench for dma_channel_regfile: directed scenarios plus random
// traffic against a behavioural model; also a NUM_CH=8, W=24 build.
module tb_dma_channel_regfile;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0;
  logic        wr, rd, step;
  logic [2:0]  sel;
  logic [1:0]  ch, xch;
  logic [7:0]  din, dout, cmd;
  logic [15:0] xaddr;
  logic        pulse;
  logic [23:0] modeF;
  logic [3:0]  msk, req;
  logic [0:0]  ptr;

  logic        rst1, wr1, rd1, step1;
  logic [2:0]  sel1, ch1w, xch1;
  logic [7:0]  din1, dout1, cmd1;
  logic [23:0] xaddr1;
  logic        pulse1;
  logic [47:0] modeF1;
  logic [7:0]  msk1, req1;
  logic [1:0]  ptr1;

  dma_channel_regfile u0 (
    .CLK(clk), .RESET(rst0),
    .prog_wr(wr), .prog_rd(rd), .prog_sel(sel),
    .prog_ch(ch), .prog_din(din), .prog_dout(dout),
    .xfer_step(step), .xfer_ch(xch), .xfer_addr(xaddr),
    .tc_pulse(pulse), .mode_flat(modeF), .command(cmd),
    .mask(msk), .request(req), .byte_ptr(ptr)
  );

  dma_channel_regfile #(.NUM_CH(8), .W(24)) u1 (
    .CLK(clk), .RESET(rst1),
    .prog_wr(wr1), .prog_rd(rd1), .prog_sel(sel1),
    .prog_ch(ch1w), .prog_din(din1), .prog_dout(dout1),
    .xfer_step(step1), .xfer_ch(xch1), .xfer_addr(xaddr1),
    .tc_pulse(pulse1), .mode_flat(modeF1), .command(cmd1),
    .mask(msk1), .request(req1), .byte_ptr(ptr1)
  );

  int checks = 0;
  int failures = 0;

  int unsigned mBA [4];
  int unsigned mCA [4];
  int unsigned mBC [4];
  int unsigned mCC [4];
  int unsigned mMode [4];
  int unsigned mCmd, mReq, mMask, mTc, mPtr, mDout;
  bit mPulse;

  task automatic mreset();
    for (int i = 0; i < 4; i++) begin
      mBA[i] = 0; mCA[i] = 0; mBC[i] = 0;
      mCC[i] = 0; mMode[i] = 0;
    end
    mCmd = 0; mReq = 0; mMask = 15; mTc = 0;
    mPtr = 0; mDout = 0; mPulse = 0;
  endtask

  function automatic int unsigned putByte(
    input int unsigned v, input int unsigned p, input int unsigned d);
    return (v & ~(32'hFF << (8*p))) | ((d & 255) << (8*p));
  endfunction

  task automatic cyc(input bit w, input bit r, input int s,
                     input int c, input int d,
                     input bit st, input int x);
    int unsigned rdv, newTc;
    bit doRd, stOk, term;
    wr = w; rd = r; sel = s[2:0]; ch = c[1:0];
    din = d[7:0]; step = st; xch = x[1:0];
    doRd = r && !w;
    stOk = st && !(w && s < 2 && c == x);
    term = stOk && (mCC[x] == 0);
    case (s)
      0: rdv = (mCA[c] >> (8*mPtr)) & 255;
      1: rdv = (mCC[c] >> (8*mPtr)) & 255;
      2: rdv = mMode[c];
      3: rdv = mCmd;
      4: rdv = mReq;
      5: rdv = mMask;
      6: rdv = ((mReq & 15) << 4) | (mTc & 15);
      default: rdv = 0;
    endcase
    newTc = mTc;
    if (doRd && s == 6) newTc = 0;
    if (stOk) begin
      if (term && ((mMode[x] >> 2) & 1) == 1) begin
        mCA[x] = mBA[x];
        mCC[x] = mBC[x];
      end else begin
        if (((mMode[x] >> 3) & 1) == 1)
          mCA[x] = (mCA[x] + 65535) % 65536;
        else
          mCA[x] = (mCA[x] + 1) % 65536;
        mCC[x] = (mCC[x] + 65535) % 65536;
      end
      if (term) newTc = newTc | (1 << x);
    end
    if (w) begin
      case (s)
        0: begin
          mBA[c] = putByte(mBA[c], mPtr, d);
          mCA[c] = putByte(mCA[c], mPtr, d);
          mPtr = (mPtr + 1) % 2;
        end
        1: begin
          mBC[c] = putByte(mBC[c], mPtr, d);
          mCC[c] = putByte(mCC[c], mPtr, d);
          mPtr = (mPtr + 1) % 2;
        end
        2: mMode[c] = d & 63;
        3: mCmd = d & 255;
        4: mReq = (mReq & ~(1 << c)) | ((d & 1) << c);
        5: mMask = (mMask & ~(1 << c)) | ((d & 1) << c);
        7: mPtr = 0;
        default: ;
      endcase
    end else if (r) begin
      mDout = rdv;
      if (s < 2) mPtr = (mPtr + 1) % 2;
      if (s == 7) begin
        mCmd = 0; mReq = 0; mMask = 15;
        mPtr = 0; newTc = 0;
      end
    end
    mTc = newTc;
    mPulse = term;
    @(posedge clk); #1;
    wr = 0; rd = 0; step = 0;
  endtask

  task automatic test_reset();
    logic [23:0] zm;
    zm = '0;
    rst0 = 1; rst1 = 1;
    wr = 0; rd = 0; step = 0; sel = 0; ch = 0; din = 0; xch = 0;
    wr1 = 0; rd1 = 0; step1 = 0; sel1 = 0; ch1w = 0; din1 = 0; xch1 = 0;
    mreset();
    @(posedge clk); #1;
    checks++; if (msk !== 4'hF) begin failures++; $display("FAIL reset_mask got=%h exp=f", msk); end
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout); end
    checks++; if (ptr !== 1'b0) begin failures++; $display("FAIL reset_ptr got=%h exp=0", ptr); end
    checks++; if (pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%b exp=0", pulse); end
    checks++; if (cmd !== 8'h00 || req !== 4'h0) begin failures++; $display("FAIL reset_cmdreq got=%h/%h exp=00/0", cmd, req); end
    checks++; if (modeF !== zm) begin failures++; $display("FAIL reset_mode got=%h exp=0", modeF); end
    rst0 = 0; rst1 = 0;
    @(posedge clk); #1;
    checks++; if (msk !== 4'hF) begin failures++; $display("FAIL release_mask got=%h exp=f", msk); end
  endtask

  task automatic test_addr_rw();
    cyc(1, 0, 0, 2, 'h34, 0, 2);
    cyc(1, 0, 0, 2, 'h12, 0, 2);
    checks++; if (xaddr !== 16'h1234) begin failures++; $display("FAIL addr_xaddr got=%h exp=1234", xaddr); end
    cyc(0, 1, 0, 2, 0, 0, 2);
    checks++; if (dout !== 8'h34) begin failures++; $display("FAIL addr_rd0 got=%h exp=34", dout); end
    cyc(0, 1, 0, 2, 0, 0, 2);
    checks++; if (dout !== 8'h12) begin failures++; $display("FAIL addr_rd1 got=%h exp=12", dout); end
  endtask

  task automatic test_terminal_count();
    cyc(1, 0, 2, 1, 0, 0, 1);
    cyc(1, 0, 0, 1, 'h00, 0, 1);
    cyc(1, 0, 0, 1, 'h10, 0, 1);
    cyc(1, 0, 1, 1, 'h01, 0, 1);
    cyc(1, 0, 1, 1, 'h00, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 1);
    checks++; if (pulse !== 1'b0) begin failures++; $display("FAIL tc_step1_pulse got=%b exp=0", pulse); end
    cyc(0, 0, 0, 0, 0, 1, 1);
    checks++; if (pulse !== 1'b1) begin failures++; $display("FAIL tc_step2_pulse got=%b exp=1", pulse); end
    checks++; if (xaddr !== 16'h1002) begin failures++; $display("FAIL tc_addr got=%h exp=1002", xaddr); end
    cyc(0, 0, 0, 0, 0, 0, 1);
    checks++; if (pulse !== 1'b0) begin failures++; $display("FAIL tc_pulse_len got=%b exp=0", pulse); end
    cyc(0, 1, 1, 1, 0, 0, 1);
    checks++; if (dout !== 8'hFF) begin failures++; $display("FAIL tc_cnt_lo got=%h exp=ff", dout); end
    cyc(0, 1, 1, 1, 0, 0, 1);
    checks++; if (dout !== 8'hFF) begin failures++; $display("FAIL tc_cnt_hi got=%h exp=ff", dout); end
    cyc(0, 1, 6, 0, 0, 0, 1);
    checks++; if (dout !== 8'h02) begin failures++; $display("FAIL tc_status got=%h exp=02", dout); end
    cyc(0, 1, 6, 0, 0, 0, 1);
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL tc_status2 got=%h exp=00", dout); end
  endtask

  task automatic test_autoinit();
    cyc(1, 0, 2, 0, 'h04, 0, 0);
    cyc(1, 0, 0, 0, 'h00, 0, 0);
    cyc(1, 0, 0, 0, 'h20, 0, 0);
    cyc(1, 0, 1, 0, 'h00, 0, 0);
    cyc(1, 0, 1, 0, 'h00, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    checks++; if (pulse !== 1'b1) begin failures++; $display("FAIL ai_pulse got=%b exp=1", pulse); end
    checks++; if (xaddr !== 16'h2000) begin failures++; $display("FAIL ai_addr got=%h exp=2000", xaddr); end
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL ai_cnt got=%h exp=00", dout); end
    cyc(0, 1, 2, 0, 0, 0, 0);
    checks++; if (dout !== 8'h04) begin failures++; $display("FAIL ai_mode_rd got=%h exp=04", dout); end
    cyc(0, 1, 6, 0, 0, 0, 0);
    checks++; if (dout !== 8'h01) begin failures++; $display("FAIL ai_status got=%h exp=01", dout); end
  endtask

  task automatic test_decrement();
    cyc(1, 0, 2, 3, 'h08, 0, 3);
    cyc(1, 0, 0, 3, 'h00, 0, 3);
    cyc(1, 0, 0, 3, 'h00, 0, 3);
    cyc(0, 0, 0, 0, 0, 1, 3);
    checks++; if (xaddr !== 16'hFFFF) begin failures++; $display("FAIL dec_wrap got=%h exp=ffff", xaddr); end
    checks++; if (pulse !== mPulse) begin failures++; $display("FAIL dec_pulse got=%b exp=%b", pulse, mPulse); end
    cyc(1, 0, 0, 3, 'h77, 0, 3);
    checks++; if (ptr !== 1'b1) begin failures++; $display("FAIL dec_ptr1 got=%h exp=1", ptr); end
    cyc(1, 0, 7, 0, 0, 0, 3);
    checks++; if (ptr !== 1'b0) begin failures++; $display("FAIL clrptr got=%h exp=0", ptr); end
    cyc(1, 0, 0, 3, 'hAA, 0, 3);
    checks++; if (xaddr !== 16'hFFAA) begin failures++; $display("FAIL clrptr_low got=%h exp=ffaa", xaddr); end
  endtask

  task automatic test_master_clear();
    cyc(1, 0, 3, 0, 'h55, 0, 2);
    cyc(1, 0, 4, 0, 1, 0, 2);
    cyc(1, 0, 4, 1, 1, 0, 2);
    for (int i = 0; i < 4; i++) cyc(1, 0, 5, i, 0, 0, 2);
    checks++; if (cmd !== 8'h55 || req !== 4'h3 || msk !== 4'h0) begin failures++; $display("FAIL mc_setup got=%h/%h/%h exp=55/3/0", cmd, req, msk); end
    checks++; if (ptr !== 1'b1) begin failures++; $display("FAIL mc_ptr_pre got=%h exp=1", ptr); end
    cyc(0, 1, 7, 0, 0, 0, 2);
    checks++; if (cmd !== 8'h00 || req !== 4'h0) begin failures++; $display("FAIL mc_cmdreq got=%h/%h exp=00/0", cmd, req); end
    checks++; if (msk !== 4'hF || ptr !== 1'b0) begin failures++; $display("FAIL mc_maskptr got=%h/%h exp=f/0", msk, ptr); end
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL mc_dout got=%h exp=00", dout); end
    checks++; if (xaddr !== 16'(mCA[2])) begin failures++; $display("FAIL mc_keep_addr got=%h exp=%h", xaddr, mCA[2]); end
    cyc(0, 1, 7, 0, 0, 1, 0);
    checks++; if (pulse !== 1'b1) begin failures++; $display("FAIL mc_tc_pulse got=%b exp=1", pulse); end
    cyc(0, 1, 6, 0, 0, 0, 0);
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL mc_tc_clear got=%h exp=00", dout); end
  endtask

  task automatic test_back_to_back();
    cyc(1, 0, 0, 0, 'h99, 1, 0);
    checks++; if (pulse !== 1'b0) begin failures++; $display("FAIL b2b_no_tc got=%b exp=0", pulse); end
    checks++; if (xaddr !== 16'h2099) begin failures++; $display("FAIL b2b_write_wins got=%h exp=2099", xaddr); end
    cyc(1, 0, 0, 2, 'h5A, 1, 0);
    checks++; if (pulse !== 1'b1) begin failures++; $display("FAIL b2b_other_ch got=%b exp=1", pulse); end
    checks++; if (xaddr !== 16'(mCA[0])) begin failures++; $display("FAIL b2b_reload got=%h exp=%h", xaddr, mCA[0]); end
    cyc(1, 0, 7, 0, 0, 0, 3);
    cyc(1, 0, 1, 3, 0, 0, 3);
    cyc(1, 0, 1, 3, 0, 0, 3);
    cyc(0, 0, 0, 0, 0, 1, 3);
    cyc(0, 1, 6, 0, 0, 1, 0);
    checks++; if (dout !== 8'h09) begin failures++; $display("FAIL b2b_status_tc got=%h exp=09", dout); end
    cyc(0, 1, 6, 0, 0, 0, 0);
    checks++; if (dout !== 8'h01) begin failures++; $display("FAIL b2b_status_keep got=%h exp=01", dout); end
    cyc(1, 1, 3, 0, 'hC3, 0, 0);
    checks++; if (cmd !== 8'hC3 || dout !== 8'h01) begin failures++; $display("FAIL b2b_wr_rd got=%h/%h exp=c3/01", cmd, dout); end
  endtask

  task automatic test_wide();
    logic [7:0] bytes [3];
    bytes[0] = 8'h56; bytes[1] = 8'h34; bytes[2] = 8'h12;
    xch1 = 3'd7;
    for (int i = 0; i < 3; i++) begin
      sel1 = 3'd0; ch1w = 3'd7; din1 = bytes[i]; wr1 = 1;
      @(posedge clk); #1;
      wr1 = 0;
    end
    checks++; if (xaddr1 !== 24'h123456) begin failures++; $display("FAIL wide_addr got=%h exp=123456", xaddr1); end
    checks++; if (ptr1 !== 2'd0) begin failures++; $display("FAIL wide_ptr_wrap got=%h exp=0", ptr1); end
    din1 = 8'hEE; wr1 = 1;
    @(posedge clk); #1;
    wr1 = 0;
    checks++; if (ptr1 !== 2'd1) begin failures++; $display("FAIL wide_ptr1 got=%h exp=1", ptr1); end
    #2 rst1 = 1;
    #1;
    checks++; if (ptr1 !== 2'd0 || xaddr1 !== 24'h0) begin failures++; $display("FAIL wide_async_rst got=%h/%h exp=0/0", ptr1, xaddr1); end
    checks++; if (msk1 !== 8'hFF) begin failures++; $display("FAIL wide_rst_mask got=%h exp=ff", msk1); end
    rst1 = 0;
  endtask

  task automatic test_random();
    int w, r, s, c, d, st, x, k;
    logic [23:0] em;
    for (int n = 0; n < 400; n++) begin
      w = ($urandom_range(3) == 0);
      r = ($urandom_range(2) == 0);
      s = $urandom_range(7);
      c = $urandom_range(3);
      k = $urandom_range(3);
      d = (k == 0) ? 0 : (k == 1) ? 1 : $urandom_range(255);
      st = $urandom_range(1);
      x = $urandom_range(3);
      cyc(w[0], r[0], s, c, d, st[0], x);
      checks++; if (dout !== 8'(mDout)) begin failures++; $display("FAIL rnd_dout n=%0d got=%h exp=%h", n, dout, mDout); end
      checks++; if (pulse !== mPulse) begin failures++; $display("FAIL rnd_pulse n=%0d got=%b exp=%b", n, pulse, mPulse); end
      checks++; if (xaddr !== 16'(mCA[x])) begin failures++; $display("FAIL rnd_xaddr n=%0d got=%h exp=%h", n, xaddr, mCA[x]); end
      checks++; if (ptr !== 1'(mPtr) || msk !== 4'(mMask) || req !== 4'(mReq) || cmd !== 8'(mCmd)) begin
        failures++; $display("FAIL rnd_regs n=%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", n, ptr, msk, req, cmd, mPtr, mMask, mReq, mCmd);
      end
    end
    em = '0;
    for (int i = 0; i < 4; i++) em[6*i +: 6] = mMode[i][5:0];
    checks++; if (modeF !== em) begin failures++; $display("FAIL rnd_mode got=%h exp=%h", modeF, em); end
  endtask

  initial begin
    test_reset();
    test_addr_rw();
    test_terminal_count();
    test_autoinit();
    test_decrement();
    test_master_clear();
    test_back_to_back();
    test_wide();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_channel_regfile.md
# dma_channel_regfile

Parametrised register file and address/count engine for the DMA controller, the successor to the fixed four-channel, 16-bit datapath register set. It holds per-channel base/current address and word-count registers plus mode, command, request, mask and status, and is programmed byte-wise from the CPU bus through a byte-pointer counter. The block also steps the selected channel's registers once per completed transfer, handling terminal count and autoinitialize. It sits between the CPU bus interface and the timing FSM / priority encoder.

## Interface

- NUM_CH, 4, channel count, 1..8.
- W, 16, address and count width, multiple of 8, 8..32. NB = W/8 bytes per register.

Clocking and reset: one clock; reset is asynchronous and active-high. Ports:

- CLK  in  1  clock, rising edge.
- RESET  in  1  async active-high reset.
- prog_wr  in  1  CPU write strobe, one cycle per byte.
- prog_rd  in  1  CPU read strobe, one cycle per byte.
- prog_sel  in  3  register select: 0 addr, 1 count, 2 mode, 3 command, 4 request, 5 mask, 6 status, 7 clear-pointer (write) / master-clear (read).
- prog_ch  in  clog2(NUM_CH) (min 1)  channel for sel 0..2, 4, 5.
- prog_din  in  8  write data.
- prog_dout  out  8  read data, registered.
- xfer_step  in  1  one transfer completed on xfer_ch.
- xfer_ch  in  clog2(NUM_CH)  channel being serviced.
- xfer_addr  out  W  current address of xfer_ch, combinational.
- tc_pulse  out  1  registered, one cycle on terminal count.
- mode_flat  out  6*NUM_CH  all mode registers.
- command  out  8  command register.
- mask  out  NUM_CH  mask bits.
- request  out  NUM_CH  software request bits.
- byte_ptr  out  clog2(NB) (min 1)  byte pointer.

## Operation

- Mode bits: [1:0] transfer type, [2] autoinit, [3] address decrement, [5:4] mode.
- Addr/count write (sel 0/1): byte byte_ptr of both base and current is loaded from prog_din. byte_ptr then increments, wrapping NB-1 -> 0.
- Addr/count read: prog_dout <= byte byte_ptr of the current register. byte_ptr then advances the same way.
- There is one shared byte_ptr across channels and registers.
- Mode write loads prog_din[5:0]; mode read returns {2'b00, mode}. Command is 8-bit read/write.
- Request/mask write: prog_din[0] is loaded into bit prog_ch. Read returns the bits zero-extended.
- Status read returns {request[min(NUM_CH,4)-1:0] in [7:4], tc[min(NUM_CH,4)-1:0] in [3:0]} and clears all tc flags.
- Clear-pointer write (sel 7): byte_ptr <= 0.
- Master clear (read of sel 7): clears command, request, tc flags and byte_ptr, and sets mask to all ones. Channel address/count/mode registers are unaffected. prog_dout <= 0.
- xfer_step on channel c:
  - current addr +1, or -1 if mode[3]; wraps modulo 2^W.
  - current count -1.
  - If count was 0 before the step (0 -> all-ones): set tc[c] and pulse tc_pulse. If mode[2] is set, current addr/count are reloaded from base instead of the step results.

## Timing

- Reset values:
  - all base/current/mode registers 0, command 0, request 0, tc 0, byte_ptr 0.
  - mask all ones, prog_dout 0, tc_pulse 0.
- Writes and steps take effect at the next rising edge. prog_dout is valid the cycle after prog_rd and holds until the next read.
- prog_wr and prog_rd asserted together: the write is performed and the read is ignored.
- Programming addr/count of channel c in the same cycle as xfer_step on c: the write wins, the step is dropped and there is no tc. A step on a different channel proceeds normally.
- Status read in the same cycle as a tc event: the new tc bit stays set and the other tc bits clear.
- Master clear in the same cycle as tc: tc is cleared, tc_pulse still fires.
- tc_pulse is asserted exactly one cycle after the edge that sampled the terminal step.
- RESET asserted mid-sequence returns all outputs to reset values immediately, with no clock required.

## Test plan

- Reset with defaults: mask=4'hF, prog_dout=0, byte_ptr=0. Write ch2 addr bytes 0x34, 0x12 -> read back 0x34, 0x12; xfer_addr(ch2)=0x1234.
- Count=0x0001 on ch1 with mode=0, then 2 steps:
  - addr 0x1000 -> 0x1002.
  - count 0x0001 -> 0xFFFF.
  - tc_pulse after the 2nd step only.
  - status read = 0x02, and a 2nd status read = 0x00.
- Autoinit ch0 with mode=6'h04, base addr 0x2000, count 0x0000, one step -> current reloaded to 0x2000/0x0000, tc_pulse=1.
- Decrement ch3 with mode=6'h08, addr 0x0000, one step -> 0xFFFF (wrap). Write one addr byte, then clear-pointer, then write 0xAA -> the low byte gets 0xAA.
- Master clear after setting command=0x55, request=0x3, mask=0 -> command=0, request=0, mask=0xF, byte_ptr=0. Same-cycle addr write and step on ch0 -> written value kept, no tc.
- Build NUM_CH=8, W=24: 3-byte write 0x56, 0x34, 0x12 to ch7 -> xfer_addr=0x123456 and byte_ptr wraps to 0. Assert RESET mid-write -> byte_ptr=0 with no clock edge.
